// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation encodings
// used by the RTL and the testbench alike.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_ROL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_ASR   = 3'b101,
    MODE_LOAD  = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_t;

endpackage

// File: rtl/shift_bit_counter.sv
// Counts serial shifts and emits a registered one-cycle pulse each time
// WIDTH counted shifts have completed.
module shift_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic frame_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] count;

  // The pulse defaults low every cycle, so it can only last one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      count      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (clear) begin
        count <= '0;
      end else if (count_en) begin
        if (count == LAST) begin
          count      <= '0;
          frame_done <= 1'b1;
        end else begin
          count <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: shifts, rotates, arithmetic shift,
// parallel load and clear, with a frame counter over serial shifts.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] Q,
  output logic             serial_out,
  output logic             frame_done
);

  logic count_en;
  logic clear_cnt;

  // Only true serial shifts advance the frame; load and clear restart it.
  always_comb begin
    count_en  = enable && ((mode == MODE_SHL) || (mode == MODE_SHR));
    clear_cnt = enable && ((mode == MODE_LOAD) || (mode == MODE_CLEAR));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      Q          <= '0;
      serial_out <= 1'b0;
    end else if (enable) begin
      case (mode)
        MODE_SHL: begin
          Q          <= {Q[WIDTH-2:0], serial_in};
          serial_out <= Q[WIDTH-1];
        end
        MODE_SHR: begin
          Q          <= {serial_in, Q[WIDTH-1:1]};
          serial_out <= Q[0];
        end
        MODE_ROL: begin
          Q          <= {Q[WIDTH-2:0], Q[WIDTH-1]};
          serial_out <= Q[WIDTH-1];
        end
        MODE_ROR: begin
          Q          <= {Q[0], Q[WIDTH-1:1]};
          serial_out <= Q[0];
        end
        MODE_ASR: begin
          Q          <= {Q[WIDTH-1], Q[WIDTH-1:1]};
          serial_out <= Q[0];
        end
        MODE_LOAD:  Q <= parallel_in;
        MODE_CLEAR: Q <= '0;
        default: ;
      endcase
    end
  end

  shift_bit_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_counter (
    .clock     (clock),
    .reset     (reset),
    .count_en  (count_en),
    .clear     (clear_cnt),
    .frame_done(frame_done)
  );

endmodule

// File: tb/tb_universal_shift_register.sv
// Table-driven scoreboard bench for the universal shift register at
// WIDTH=4 and WIDTH=8.
module tb_universal_shift_register;
  import usr_pkg::*;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] md;
    logic       si;
    logic [7:0] pin;
    logic [7:0] q;
    logic       so;
    logic       fd;
  } vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, enable, serial_in, serial_out, frame_done;
  logic [2:0] mode;
  logic [3:0] parallel_in, q4;
  logic       reset8, enable8, serial_in8, serial_out8, frame_done8;
  logic [2:0] mode8;
  logic [7:0] parallel_in8, q8;

  universal_shift_register #(.WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode),
    .serial_in(serial_in), .parallel_in(parallel_in), .Q(q4),
    .serial_out(serial_out), .frame_done(frame_done)
  );

  universal_shift_register #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset8), .enable(enable8), .mode(mode8),
    .serial_in(serial_in8), .parallel_in(parallel_in8), .Q(q8),
    .serial_out(serial_out8), .frame_done(frame_done8)
  );

  int   total = 0;
  int   bad = 0;
  int   row = 0;
  vec_t tab4[$];
  vec_t tab8[$];
  vec_t sb[$];

  function automatic vec_t mk(logic rst, logic en, logic [2:0] md, logic si,
                              logic [7:0] pin, logic [7:0] q, logic so, logic fd);
    vec_t v;
    v.rst = rst; v.en = en; v.md = md; v.si = si;
    v.pin = pin; v.q = q; v.so = so; v.fd = fd;
    return v;
  endfunction

  task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic check_output(input bit wide);
    vec_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard row %0d: got empty queue expected entry", row);
      return;
    end
    e = sb.pop_front();
    if (wide) begin
      compare("q8", q8, e.q);
      compare("serial_out8", {7'd0, serial_out8}, {7'd0, e.so});
      compare("frame_done8", {7'd0, frame_done8}, {7'd0, e.fd});
    end else begin
      compare("q4", {4'd0, q4}, {4'd0, e.q[3:0]});
      compare("serial_out4", {7'd0, serial_out}, {7'd0, e.so});
      compare("frame_done4", {7'd0, frame_done}, {7'd0, e.fd});
    end
  endtask

  task automatic apply_stimulus(input bit wide, input vec_t v);
    @(negedge clock);
    if (wide) begin
      reset8 = v.rst; enable8 = v.en; mode8 = v.md;
      serial_in8 = v.si; parallel_in8 = v.pin;
    end else begin
      reset = v.rst; enable = v.en; mode = v.md;
      serial_in = v.si; parallel_in = v.pin[3:0];
    end
    sb.push_back(v);
    @(posedge clock);
    #1;
    check_output(wide);
    row++;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mode = MODE_HOLD; serial_in = 1'b0; parallel_in = '0;
    reset8 = 1'b1; enable8 = 1'b0; mode8 = MODE_HOLD; serial_in8 = 1'b0; parallel_in8 = '0;

    // WIDTH=4: reset wins over an active shift, then the 0,1,1,0 shift-in frame
    tab4.push_back(mk(1, 1, MODE_SHL,  1, 8'h0, 8'h0, 0, 0));
    tab4.push_back(mk(0, 1, MODE_SHL,  0, 8'h0, 8'h0, 0, 0));
    tab4.push_back(mk(0, 1, MODE_SHL,  1, 8'h0, 8'h1, 0, 0));
    tab4.push_back(mk(0, 1, MODE_SHL,  1, 8'h0, 8'h3, 0, 0));
    tab4.push_back(mk(0, 1, MODE_SHL,  0, 8'h0, 8'h6, 0, 1));
    tab4.push_back(mk(0, 1, MODE_HOLD, 1, 8'h0, 8'h6, 0, 0));
    // load then a full rotation cycle without any frame pulse
    tab4.push_back(mk(0, 1, MODE_LOAD, 0, 8'hB, 8'hB, 0, 0));
    tab4.push_back(mk(0, 1, MODE_ROL,  0, 8'h0, 8'h7, 1, 0));
    tab4.push_back(mk(0, 1, MODE_ROL,  0, 8'h0, 8'hE, 0, 0));
    tab4.push_back(mk(0, 1, MODE_ROL,  0, 8'h0, 8'hD, 1, 0));
    tab4.push_back(mk(0, 1, MODE_ROL,  0, 8'h0, 8'hB, 1, 0));
    // arithmetic shift ignores serial_in, then a logical right shift
    tab4.push_back(mk(0, 1, MODE_LOAD, 0, 8'h8, 8'h8, 1, 0));
    tab4.push_back(mk(0, 1, MODE_ASR,  1, 8'h0, 8'hC, 0, 0));
    tab4.push_back(mk(0, 1, MODE_ASR,  1, 8'h0, 8'hE, 0, 0));
    tab4.push_back(mk(0, 1, MODE_SHR,  0, 8'h0, 8'h7, 0, 0));
    // enable low freezes everything; count resumes from 1
    tab4.push_back(mk(0, 0, MODE_SHL,  1, 8'h0, 8'h7, 0, 0));
    tab4.push_back(mk(0, 0, MODE_SHL,  1, 8'h0, 8'h7, 0, 0));
    tab4.push_back(mk(0, 0, MODE_SHL,  1, 8'h0, 8'h7, 0, 0));
    tab4.push_back(mk(0, 1, MODE_SHL,  1, 8'h0, 8'hF, 0, 0));
    tab4.push_back(mk(0, 1, MODE_SHL,  0, 8'h0, 8'hE, 1, 0));
    tab4.push_back(mk(0, 1, MODE_SHL,  0, 8'h0, 8'hC, 1, 1));
    tab4.push_back(mk(0, 1, MODE_ROR,  0, 8'h0, 8'h6, 0, 0));
    tab4.push_back(mk(0, 1, MODE_CLEAR,0, 8'h0, 8'h0, 0, 0));
    // reset mid-frame discards the partial count
    tab4.push_back(mk(0, 1, MODE_SHL,  1, 8'h0, 8'h1, 0, 0));
    tab4.push_back(mk(0, 1, MODE_SHL,  1, 8'h0, 8'h3, 0, 0));
    tab4.push_back(mk(1, 1, MODE_SHL,  1, 8'h0, 8'h0, 0, 0));
    tab4.push_back(mk(0, 1, MODE_SHL,  1, 8'h0, 8'h1, 0, 0));
    tab4.push_back(mk(0, 1, MODE_SHL,  0, 8'h0, 8'h2, 0, 0));
    tab4.push_back(mk(0, 1, MODE_SHL,  1, 8'h0, 8'h5, 0, 0));
    tab4.push_back(mk(0, 1, MODE_SHL,  1, 8'h0, 8'hB, 0, 1));
    // mixed directions share one count
    tab4.push_back(mk(0, 1, MODE_SHR,  1, 8'h0, 8'hD, 1, 0));
    tab4.push_back(mk(0, 1, MODE_SHL,  0, 8'h0, 8'hA, 1, 0));
    tab4.push_back(mk(0, 1, MODE_SHR,  0, 8'h0, 8'h5, 0, 0));
    tab4.push_back(mk(0, 1, MODE_SHL,  0, 8'h0, 8'hA, 0, 1));
    // load mid-frame restarts the count
    tab4.push_back(mk(0, 1, MODE_SHL,  1, 8'h0, 8'h5, 1, 0));
    tab4.push_back(mk(0, 1, MODE_LOAD, 0, 8'h3, 8'h3, 1, 0));
    tab4.push_back(mk(0, 1, MODE_SHR,  0, 8'h0, 8'h1, 1, 0));
    tab4.push_back(mk(0, 1, MODE_SHR,  0, 8'h0, 8'h0, 1, 0));
    tab4.push_back(mk(0, 1, MODE_SHR,  0, 8'h0, 8'h0, 0, 0));
    tab4.push_back(mk(0, 1, MODE_SHR,  1, 8'h0, 8'h8, 0, 1));
    tab4.push_back(mk(0, 0, MODE_LOAD, 0, 8'hF, 8'h8, 0, 0));

    foreach (tab4[i]) apply_stimulus(1'b0, tab4[i]);

    // WIDTH=8: leading SHLs must not carry into the frame after LOAD
    tab8.push_back(mk(1, 0, MODE_HOLD, 0, 8'h00, 8'h00, 0, 0));
    for (int i = 0; i < 3; i++)
      tab8.push_back(mk(0, 1, MODE_SHL, 1, 8'h00, 8'((1 << (i + 1)) - 1), 0, 0));
    tab8.push_back(mk(0, 1, MODE_LOAD, 0, 8'hA5, 8'hA5, 0, 0));
    tab8.push_back(mk(0, 1, MODE_SHR,  0, 8'h00, 8'h52, 1, 0));
    tab8.push_back(mk(0, 1, MODE_SHR,  0, 8'h00, 8'h29, 0, 0));
    tab8.push_back(mk(0, 1, MODE_SHR,  0, 8'h00, 8'h14, 1, 0));
    tab8.push_back(mk(0, 1, MODE_SHR,  0, 8'h00, 8'h0A, 0, 0));
    tab8.push_back(mk(0, 1, MODE_SHR,  0, 8'h00, 8'h05, 0, 0));
    tab8.push_back(mk(0, 1, MODE_SHR,  0, 8'h00, 8'h02, 1, 0));
    tab8.push_back(mk(0, 1, MODE_SHR,  0, 8'h00, 8'h01, 0, 0));
    tab8.push_back(mk(0, 1, MODE_SHR,  0, 8'h00, 8'h00, 1, 1));
    tab8.push_back(mk(0, 1, MODE_HOLD, 0, 8'h00, 8'h00, 1, 0));

    foreach (tab8[i]) apply_stimulus(1'b1, tab8[i]);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 4: register width in bits; legal values are 2 and above.
- CNT_W, default $clog2(WIDTH+1): width of the internal shift counter.

REQ-002 Ports SHALL be:
- clock, input, 1: the single clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: when 0, all state holds.
- mode, input, 3: operation select, encoded per REQ-005.
- serial_in, input, 1: serial data entering the register.
- parallel_in, input, WIDTH: data captured by LOAD.
- Q, output, WIDTH: register contents, driven directly from flops.
- serial_out, output, 1: registered copy of the last bit shifted or rotated out.
- frame_done, output, 1: one-cycle pulse after WIDTH counted shifts.

REQ-003 The block SHALL have exactly one clock and a synchronous active-high reset; there SHALL be no asynchronous state change.

Function
REQ-004 When enable=0, Q, serial_out and the shift counter SHALL hold, and frame_done SHALL be 0 in the next cycle.

REQ-005 When enable=1, mode SHALL select the operation applied at the rising edge:
- 000 HOLD: Q is unchanged.
- 001 SHL: Q <= {Q[WIDTH-2:0], serial_in}, and serial_out <= Q[WIDTH-1].
- 010 SHR: Q <= {serial_in, Q[WIDTH-1:1]}, and serial_out <= Q[0].
- 011 ROL: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}, and serial_out <= Q[WIDTH-1].
- 100 ROR: Q <= {Q[0], Q[WIDTH-1:1]}, and serial_out <= Q[0].
- 101 ASR: Q <= {Q[WIDTH-1], Q[WIDTH-1:1]}, and serial_in is ignored; serial_out <= Q[0].
- 110 LOAD: Q <= parallel_in.
- 111 CLEAR: Q <= 0.

REQ-006 serial_out SHALL change only on SHL, SHR, ROL, ROR and ASR; it SHALL hold on HOLD, LOAD and CLEAR.

REQ-007 The shift counter SHALL increment only on SHL and SHR; ROL, ROR, ASR and HOLD SHALL leave it unchanged.

REQ-008 LOAD and CLEAR SHALL reset the counter to 0 and SHALL force frame_done to 0 in the next cycle.

REQ-009 When an SHL or SHR occurs with counter = WIDTH-1, the counter SHALL wrap to 0 and frame_done SHALL be 1 for exactly the following cycle.

REQ-010 Mixed SHL and SHR operations SHALL accumulate in the same counter; a direction change does not clear it.

REQ-011 frame_done SHALL be registered, SHALL never stay high for two consecutive cycles without a further WIDTH counted shifts, and SHALL be 0 in every cycle not covered by REQ-009.

REQ-012 Latency for all operations SHALL be one clock: the result is visible on Q the cycle after the edge.

REQ-013 Q SHALL drive directly from flops with no combinational path from inputs to any output.

Reset
REQ-014 With reset=1 at a rising edge, the block SHALL set Q=0, serial_out=0, counter=0 and frame_done=0, regardless of enable and mode.

REQ-015 Reset SHALL take priority over every mode; a reset mid-frame SHALL discard the partial count.

REQ-016 After reset deasserts, the first operation SHALL execute on the next rising edge.

Structure
REQ-017 The mode encodings (HOLD, SHL, SHR, ROL, ROR, ASR, LOAD, CLEAR) SHALL be constants in a shared package usr_pkg, used by both the RTL and the bench.

REQ-018 The counter and frame_done generation SHALL be one sub-module, shift_bit_counter, with parameter WIDTH and inputs clock, reset, count_en and clear.

REQ-019 The data path SHALL be a single WIDTH-bit register with a mode multiplexer; the block SHALL NOT chain per-bit flip-flop instances.

Verification
REQ-020 With WIDTH=4, from reset, apply SHL with serial_in=0,1,1,0 over 4 edges. Q SHALL read 0000, 0001, 0011, 0110, and frame_done SHALL be 1 only in the cycle after edge 4.

REQ-021 LOAD 1011, then ROL once: Q SHALL be 0111 and serial_out SHALL be 1. Three further ROL operations SHALL return Q to 1011, and frame_done SHALL stay 0 throughout.

REQ-022 LOAD 1000, then ASR twice: Q SHALL read 1100 then 1110, and serial_out SHALL read 0 then 0. A subsequent SHR with serial_in=0 SHALL give Q=0111 and serial_out=0.

REQ-023 Apply two SHL operations, then reset for one cycle, then SHL operations: frame_done SHALL first rise only after 4 post-reset shifts, and Q SHALL be 0000 in the cycle after reset.

REQ-024 Hold enable=0 with mode=SHL and serial_in=1 for 3 cycles: Q, serial_out and the count SHALL be unchanged, and frame_done SHALL be 0.

REQ-025 With WIDTH=8, apply 3 SHL, then LOAD 0xA5, then 8 SHR: frame_done SHALL pulse once, after the 8th SHR, and not after the earlier SHL operations.
